// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the M-extension multiply/divide unit
// op encodings follow RV funct3, FSM states for the iterative sequencer
package mdu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] o);
    return o inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input logic [2:0] o);
    return o inside {REM, REMU};
  endfunction

  function automatic logic signed_a(input logic [2:0] o);
    return o inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic signed_b(input logic [2:0] o);
    return o inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one radix-2 step, shift-add multiply or restoring divide
// purely combinational; the caller owns acc/lo/opnd registers
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN:0]   acc_n,
  output logic [XLEN-1:0] lo_n
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN+1:0] diff;

  always_comb begin
    addend = lo[0] ? opnd : '0;
    sum    = acc + {1'b0, addend};
    shl    = {acc[XLEN-1:0], lo[XLEN-1]};
    diff   = {1'b0, shl} - {2'b00, opnd};
    if (is_div) begin
      // borrow out means the trial subtract failed: restore
      acc_n = diff[XLEN+1] ? shl : diff[XLEN:0];
      lo_n  = {lo[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      acc_n = {1'b0, sum[XLEN:1]};
      lo_n  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV M-extension unit, one step per cycle
// magnitudes are iterated, sign fixed up on the way into FIN
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);

  mdu_state_e state_q;
  mdu_state_e state_n;
  mdu_op_e    op_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic [XLEN:0]    acc_q;
  logic [XLEN:0]    step_acc;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  opnd_q;
  logic [XLEN-1:0]  step_lo;
  logic             neg_q;
  logic             spec_q;

  logic             accept;
  logic             sa;
  logic             sb;
  logic             div0;
  logic             ovf;
  logic             spec_in;
  logic             neg_in;
  logic             fin_load;
  logic [XLEN-1:0]  mag_a;
  logic [XLEN-1:0]  mag_b;
  logic [XLEN-1:0]  spec_val;
  logic [XLEN-1:0]  qr;
  logic [XLEN-1:0]  fix_val;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;

  mdu_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .is_div(is_div(op_q)),
    .acc   (acc_q),
    .lo    (lo_q),
    .opnd  (opnd_q),
    .acc_n (step_acc),
    .lo_n  (step_lo)
  );

  always_comb begin
    accept  = (state_q == IDLE) && start && !kill;
    sa      = signed_a(op) && a[XLEN-1];
    sb      = signed_b(op) && b[XLEN-1];
    mag_a   = sa ? -a : a;
    mag_b   = sb ? -b : b;
    div0    = is_div(op) && (b == '0);
    ovf     = is_div(op) && signed_b(op)
              && (a == MIN_NEG) && (b == '1);
    spec_in = div0 || ovf;
    // remainder follows the dividend, quotient the xor
    neg_in  = is_rem(op) ? sa : (sa ^ sb);
    if (div0) begin
      spec_val = is_rem(op) ? a : '1;
    end else begin
      spec_val = is_rem(op) ? '0 : a;
    end
  end

  always_comb begin
    cnt_n  = cnt_q + CNT_W'(1);
    prod   = {step_acc[XLEN-1:0], step_lo};
    prod_s = neg_q ? -prod : prod;
    qr     = is_rem(op_q) ? step_acc[XLEN-1:0] : step_lo;
    if (is_div(op_q)) begin
      fix_val = neg_q ? -qr : qr;
    end else if (op_q == MUL) begin
      fix_val = prod_s[XLEN-1:0];
    end else begin
      fix_val = prod_s[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_n = CALC;
      end
      CALC: begin
        if (kill) begin
          state_n = IDLE;
        end else if (spec_q || cnt_n == LAST) begin
          state_n = FIN;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign fin_load = (state_q == CALC) && (state_n == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= MUL;
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
    end else begin
      busy <= (state_n != IDLE);
      done <= (state_n == FIN);
      if (accept) begin
        op_q   <= mdu_op_e'(op);
        cnt_q  <= '0;
        acc_q  <= '0;
        lo_q   <= spec_in ? spec_val : mag_a;
        opnd_q <= mag_b;
        neg_q  <= neg_in;
        spec_q <= spec_in;
      end else if (state_q == CALC && !spec_q) begin
        acc_q <= step_acc;
        lo_q  <= step_lo;
        cnt_q <= cnt_n;
      end
      if (fin_load) begin
        result <= spec_q ? lo_q : fix_val;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for the iterative mul/div unit
// expected results come from a 64-bit reference model
module tb_mul_div_unit;

  typedef struct {
    logic [31:0] res;
    int          lat;
    longint      t0;
    logic [2:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  exp_t        sb[$];
  exp_t        mon_e;
  longint      cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ndone = 0;
  logic [31:0] last_exp = 32'd0;

  mul_div_unit #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .kill  (kill),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    logic        ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p  = 64'd0;
    case (o)
      3'd0: begin
        p = {32'd0, x} * {32'd0, y};
        return p[31:0];
      end
      3'd1: begin
        p = sx * sy;
        return p[63:32];
      end
      3'd2: begin
        p = sx * longint'({32'd0, y});
        return p[63:32];
      end
      3'd3: begin
        p = {32'd0, x} * {32'd0, y};
        return p[63:32];
      end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ov) return x;
        return $signed(x) / $signed(y);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ov) return 32'd0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o,
                                input logic [31:0] x,
                                input logic [31:0] y);
    logic sp;
    sp = o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000
                               && y == 32'hFFFF_FFFF));
    return sp ? 2 : 33;
  endfunction

  // waits for idle, drives one start and pushes the expectation
  task automatic issue(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input bit push);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_issue", busy, 0);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    e.res = model(o, x, y);
    e.lat = lat_of(o, x, y);
    e.t0  = cyc;
    e.op  = o;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("accepted", busy, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      ndone++;
      chk("busy_with_done", busy, 1);
      chk("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk($sformatf("res_op%0d", mon_e.op), result, mon_e.res);
        chk($sformatf("lat_op%0d", mon_e.op),
            cyc - mon_e.t0, mon_e.lat);
        last_exp = mon_e.res;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog busy=%0b done=%0b", busy, done);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    int          sel;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    wait_done();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    issue(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    wait_done();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done();
    issue(3'd5, 32'd100, 32'd7, 1'b1);
    wait_done();
    issue(3'd7, 32'd100, 32'd7, 1'b1);
    wait_done();
    issue(3'd5, 32'd5, 32'd0, 1'b1);
    wait_done();
    issue(3'd6, 32'd5, 32'd0, 1'b1);
    wait_done();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    issue(3'd4, 32'd123, 32'hFFFF_FFF6, 1'b1);
    wait_done();

    for (int i = 0; i < 16; i++) begin
      ro  = 3'($urandom_range(0, 7));
      rx  = $urandom;
      sel = $urandom_range(0, 4);
      if (sel == 0) ry = 32'd0;
      else if (sel == 1) ry = 32'($urandom_range(1, 9));
      else if (sel == 2) ry = -32'($urandom_range(1, 9));
      else ry = $urandom;
      if (i % 5 == 0) rx = 32'h8000_0000;
      issue(ro, rx, ry, 1'b1);
      wait_done();
    end

    issue(3'd7, 32'd100, 32'd7, 1'b1);
    wait_done();

    // kill at cycle 10 of an in-flight op
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    n0 = ndone;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("kill_no_done", ndone - n0, 0);
    chk("kill_result_hold", result, last_exp);

    // kill and start together in IDLE
    n0 = ndone;
    start = 1'b1;
    kill = 1'b1;
    op = 3'd0;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    kill = 1'b0;
    chk("kill_start_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("kill_start_no_done", ndone - n0, 0);

    // restarts while busy must not disturb the op in flight
    issue(3'd4, 32'hFFFF_FC18, 32'd7, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      start = 1'b1;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();
    issue(3'd0, 32'h0001_0001, 32'h0000_1234, 1'b1);
    wait_done();

    // asynchronous reset in the middle of CALC
    issue(3'd5, 32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    n0 = ndone;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = 32'd0;
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    wait_done();
    chk("arst_one_done", ndone - n0, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have parameter CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL have port op  input  3  funct3 of RV M-extension: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port a  input  XLEN  rs1 operand, captured with start.
REQ-008 SHALL have port b  input  XLEN  rs2 operand, captured with start.
REQ-009 SHALL have port kill  input  1  abort in-flight operation (branch flush).
REQ-010 SHALL have port busy  output  1  operation in flight; start ignored.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result  output  XLEN  result; held until next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIN; IDLE->CALC on accepted start, CALC->FIN when counter reaches XLEN, FIN->IDLE unconditionally.
REQ-014 SHALL accept start only in IDLE; op, a, b registered in the accept cycle (cycle 0); start while busy=1 ignored without effect.
REQ-015 SHALL assert busy from cycle 1 through the done cycle inclusive; busy=0 in IDLE.
REQ-016 SHALL compute on operand magnitudes, one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per CALC cycle, then apply sign correction in FIN.
REQ-017 SHALL pulse done at cycle XLEN+1 for normal operations (33 for XLEN=32), with result updated in that same cycle.
REQ-018 SHALL return low XLEN bits of the 2*XLEN product for MUL; high XLEN bits for MULH (s*s), MULHSU (s*u), MULHU (u*u).
REQ-019 SHALL truncate DIV quotient toward zero; REM sign SHALL follow dividend.
REQ-020 SHALL, for divide by zero, skip CALC and pulse done at cycle 2: DIV/DIVU -> all-ones, REM/REMU -> a.
REQ-021 SHALL, for DIV/REM with a = most-negative and b = all-ones, skip CALC, done at cycle 2: quotient = a, remainder = 0.
REQ-022 SHALL, on kill in any non-IDLE state, return to IDLE next cycle, suppress done, leave result unchanged.
REQ-023 SHALL give kill priority over start in the same IDLE cycle (start dropped).
REQ-024 SHALL accept a new start in the cycle immediately after done (back-to-back issue).

Reset
REQ-025 SHALL, on rst high, immediately force state IDLE, busy=0, done=0, result=0, counter=0, internal operand/accumulator registers 0.
REQ-026 SHALL discard any in-flight operation on reset mid-operation; no done after rst deasserts.
REQ-027 SHALL accept start in the first clock edge after rst deasserts.

Structure
REQ-028 SHALL place the op encoding enum (MUL..REMU) and FSM state enum in shared package mdu_pkg.
REQ-029 SHALL use one sub-module mdu_iter_core: per-step shift-add/shift-subtract datapath on XLEN+1-bit accumulator, no state of its own beyond registers it is handed.
REQ-030 SHALL register all outputs; no combinational path from inputs to busy, done, result.

Verification (XLEN=32)
REQ-031 SHALL cover: MUL a=7, b=0xFFFFFFFD -> done at cycle 33, result 0xFFFFFFEB; MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-033 SHALL cover: DIVU a=5, b=0 -> 0xFFFFFFFF at cycle 2; REM a=5, b=0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-034 SHALL cover: start at cycle 0, kill at cycle 10 -> busy=0 at cycle 11, no done, result retains previous value; kill+start same IDLE cycle -> nothing accepted.
REQ-035 SHALL cover: start repeated at cycles 1..20 while busy -> ignored, first op's result unaffected; new start in cycle after done -> accepted, done 33 cycles later.
REQ-036 SHALL cover: rst asserted asynchronously mid-CALC (between clock edges) -> outputs 0 immediately, no done thereafter.
